// File: rtl/wb_dma_master_pkg.sv
// Shared types and constants for the Wishbone DMA master: FSM state encoding,
// transfer direction codes and the full-word byte-select mask.
package wb_dma_master_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        BUS   = 3'd2,
        PUSH  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } dma_state_e;

    localparam logic       DIR_TO_MEM    = 1'b0;
    localparam logic       DIR_TO_STREAM = 1'b1;
    localparam logic [3:0] WB_FULL_MASK  = 4'hF;

endpackage

// File: rtl/wb_dma_master.sv
// Single-channel Wishbone DMA master moving 32-bit words between a stream port and memory.
// Optional ack timeout enabled by defining WB_DMA_TIMEOUT_EN.
module wb_dma_master
    import wb_dma_master_pkg::*;
#(
    parameter int MAX_WORDS      = 128,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       wb_clk,
    input  logic                       wb_rst,
    input  logic                       start,
    input  logic                       dir,
    input  logic [31:0]                base_addr,
    input  logic [$clog2(MAX_WORDS):0] word_cnt,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    input  logic [31:0]                rx_data,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    output logic [31:0]                tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [31:0]                wbm_addr,
    output logic [31:0]                wbm_dout,
    input  logic [31:0]                wbm_din,
    output logic [3:0]                 wbm_dm,
    output logic                       wbm_cyc,
    output logic                       wbm_stb,
    output logic                       wbm_we,
    input  logic                       wbm_ack,
    output dma_state_e                 dbg_state
);

    localparam int              CW      = $clog2(MAX_WORDS) + 1;
    localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_WORDS);

    dma_state_e    state_q, state_d;
    logic [29:0]   addr_q, addr_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          dir_q, dir_d;
    logic [31:0]   dout_q, dout_d;
    logic [31:0]   txd_q, txd_d;
    logic          start_acc;
    logic          tmo_hit;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^base_addr[1:0];
    assign start_acc        = (state_q == IDLE) && start && !abort;

`ifdef WB_DMA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    logic          err_q;

    assign tmo_hit = (state_q == BUS) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign err     = err_q;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= (state_q == BUS && state_d == BUS) ? tmo_q + 1'b1 : '0;
            if (state_d == ERR)
                err_q <= 1'b1;
            else if (start_acc)
                err_q <= 1'b0;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        dout_d  = dout_q;
        txd_d   = txd_q;
        unique case (state_q)
            IDLE: begin
                if (start_acc) begin
                    addr_d = base_addr[31:2];
                    rem_d  = (word_cnt > MAX_CNT) ? MAX_CNT : word_cnt;
                    dir_d  = dir;
                    if (word_cnt == '0)
                        state_d = DONE;
                    else if (dir == DIR_TO_MEM)
                        state_d = FETCH;
                    else
                        state_d = BUS;
                end
            end
            FETCH: begin
                if (rx_valid) begin
                    dout_d  = rx_data;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (wbm_ack) begin
                    addr_d = addr_q + 30'd1;
                    rem_d  = rem_q - 1'b1;
                    if (dir_q == DIR_TO_STREAM) begin
                        txd_d   = wbm_din;
                        state_d = PUSH;
                    end else if (rem_q == CW'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                    end
                end else if (tmo_hit) begin
                    state_d = ERR;
                end
            end
            PUSH: begin
                if (tx_ready)
                    state_d = (rem_q == '0) ? DONE : BUS;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort overrides every transition but still lets an acked access update the counters.
        if (abort && state_q != IDLE)
            state_d = IDLE;
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            dout_q  <= '0;
            txd_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            dout_q  <= dout_d;
            txd_q   <= txd_d;
        end
    end

    // Streams are valid/ready: a beat moves on the edge where both are high, and the
    // producer keeps data stable while valid is high.
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign rx_ready  = (state_q == FETCH);
    assign tx_valid  = (state_q == PUSH);
    assign tx_data   = txd_q;
    assign wbm_cyc   = (state_q == BUS);
    assign wbm_stb   = (state_q == BUS);
    assign wbm_we    = (state_q == BUS) && (dir_q == DIR_TO_MEM);
    assign wbm_dm    = (state_q == BUS) ? WB_FULL_MASK : 4'h0;
    assign wbm_addr  = {addr_q, 2'b00};
    assign wbm_dout  = dout_q;
    assign dbg_state = state_q;

endmodule

// File: doc/wb_dma_master.md
WB_DMA_MASTER -- requirements
Module: wb_dma_master

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 128, giving the largest transfer length in 32-bit words.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256, giving the ack-wait limit used only when WB_DMA_TIMEOUT_EN is defined.
REQ-003 SHALL have port wb_clk  in  1  single clock for all logic.
REQ-004 SHALL have port wb_rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports start in 1 (begin transfer), dir in 1 (0 = stream to memory, 1 = memory to stream), base_addr in 32 (byte address, bits [1:0] ignored), word_cnt in $clog2(MAX_WORDS)+1 (words to move), abort in 1 (cancel transfer).
REQ-006 SHALL have ports busy out 1, done out 1 (one-cycle pulse), err out 1 (sticky timeout flag).
REQ-007 SHALL have ports rx_data in 32, rx_valid in 1, rx_ready out 1, which form the inbound stream.
REQ-008 SHALL have ports tx_data out 32, tx_valid out 1, tx_ready in 1, which form the outbound stream.
REQ-009 SHALL have Wishbone master ports wbm_addr out 32, wbm_dout out 32, wbm_din in 32, wbm_dm out 4, wbm_cyc out 1, wbm_stb out 1, wbm_we out 1, wbm_ack in 1.

Function
REQ-010 SHALL implement states IDLE, FETCH, BUS, PUSH, DONE and ERR; busy SHALL be 1 in every state except IDLE.
REQ-011 In IDLE, start=1 SHALL latch base_addr[31:2], word_cnt and dir; the block SHALL go to DONE if word_cnt=0, else to FETCH if dir=0, else to BUS.
REQ-012 A start asserted while not in IDLE SHALL be ignored.
REQ-013 A word_cnt greater than MAX_WORDS SHALL be clamped to MAX_WORDS.
REQ-014 In FETCH, rx_ready SHALL be 1; on rx_valid&rx_ready the block SHALL capture rx_data into wbm_dout and go to BUS next cycle; rx_ready SHALL be 0 in all other states.
REQ-015 In BUS, wbm_cyc, wbm_stb=1, wbm_we=~dir and wbm_dm=4'hF; wbm_addr, wbm_dout and wbm_we SHALL be held stable until ack.
REQ-016 On wbm_ack in BUS: the address SHALL advance by 4 (wrapping modulo 2^32) and remaining SHALL decrement by 1; for dir=1, wbm_din SHALL be registered into tx_data and the block SHALL go to PUSH; for dir=0, the block SHALL go to DONE if remaining reaches 0, else to FETCH.
REQ-017 wbm_cyc and wbm_stb SHALL be 0 for at least one cycle between consecutive accesses; there are no bursts and no pipelined strobes.
REQ-018 In PUSH, tx_valid SHALL be 1 with tx_data stable; on tx_ready the block SHALL go to DONE if remaining=0, else to BUS.
REQ-019 wbm_ack received outside BUS SHALL be ignored.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-021 abort=1 in any non-IDLE state SHALL deassert cyc/stb/rx_ready/tx_valid on the next edge and return to IDLE, with no done pulse and no bus write issued after that edge.
REQ-022 If abort coincides with wbm_ack, the acked access SHALL count, but no further access SHALL start.
REQ-023 start and abort in the same IDLE cycle: abort SHALL win and no transfer SHALL start.
REQ-024 err SHALL be cleared by the next accepted start.

Reset
REQ-025 wb_rst SHALL force IDLE and zero busy, done, err, rx_ready, tx_valid, tx_data, wbm_cyc, wbm_stb, wbm_we, wbm_addr, wbm_dout, wbm_dm, the internal address and remaining counter.
REQ-026 wb_rst mid-transfer SHALL drop wbm_cyc/wbm_stb on the same edge; the partial transfer is lost.

Configuration
REQ-027 With WB_DMA_TIMEOUT_EN defined, a counter SHALL run in BUS; if no ack arrives after TIMEOUT_CYCLES cycles, the block SHALL drop cyc/stb, set err, enter ERR for one cycle and then go to IDLE, with no done pulse.
REQ-028 Without WB_DMA_TIMEOUT_EN, BUS SHALL wait indefinitely, err SHALL be constant 0, and no counter logic SHALL exist.

Structure
REQ-029 The shared package SHALL hold the state enum, the DIR_TO_MEM/DIR_TO_STREAM constants and the full-word byte mask 4'hF.
REQ-030 The design SHALL be a single module with no sub-module; the datapath is one register per direction.

Verification
REQ-031 dir=0, base 0x100, cnt 4, rx words 0xA0..0xA3 with the slave acking 1 cycle after stb -> writes to 0x100/104/108/10C with dm=F, exactly one done pulse, busy 0 afterwards.
REQ-032 dir=1, base 0xFFC, cnt 2, slave returns 0x11 then 0x22, tx_ready held 0 for 5 cycles -> tx_data stays 0x11 with tx_valid high, the second read goes to 0x1000, then done.
REQ-033 cnt=0 -> no cyc ever, done 2 cycles after start; base 0xFFFFFFFC with cnt 2 -> second access at 0x00000000.
REQ-034 abort during the second BUS of a 4-word write -> cyc low the next cycle, no done, a subsequent start runs normally.
REQ-035 With WB_DMA_TIMEOUT_EN, slave never acks -> cyc drops after 256 cycles, err=1, no done; without the macro -> cyc held for 1000 cycles.
REQ-036 wb_rst asserted in PUSH -> all outputs 0 on the next edge; start ignored while busy.
